puck_trail_display: RTL and testbench
=====================================

# puck_trail_display

Display back end for the air-hockey game. Consumes the puck coordinates produced by the game FSM and keeps a 4-deep history of distinct puck positions. Drives the 5-LED X-position bar and an 8-digit multiplexed seven-segment display showing that trail. Sits between the game controller's X_COORD/Y_COORD outputs and the board's LED/SSD pins.

## Interface
Parameters:
- SCAN_DIV, 50000, clock cycles per digit during display multiplexing; legal range 2 to 2^20-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- clr  in  1  synchronous history clear, used on game restart
- X_COORD  in  3  puck column; legal values 0..4
- Y_COORD  in  3  puck row; legal values 0..4
- MOVED  out  1  one-cycle pulse when a new position is captured
- LEDX  out  5  one-hot of the newest X position; all zero when the history is empty
- AN  out  8  digit enables, active-low
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low

## Operation
- History holds entries h0 (newest) to h3 (oldest). Each entry is {x[2:0], y[2:0]}. A 3-bit count tracks valid entries and saturates at 4.
- Capture condition, evaluated every cycle:
  - X_COORD ≤ 4, Y_COORD ≤ 4, and
  - either count==0 or (X_COORD,Y_COORD) ≠ h0.
- On capture:
  - shift h3←h2, h2←h1, h1←h0, h0←input;
  - count ← min(count+1, 4);
  - MOVED ← 1;
  - LEDX ← 1<<X_COORD.
- Otherwise MOVED ← 0 and the history is unchanged.
- Out-of-range input (either coordinate >4) is ignored: no capture, no pulse.
- clr=1:
  - count ← 0, entries ← 0, LEDX ← 0, MOVED ← 0;
  - clr has priority over a simultaneous capture; that input is discarded;
  - the same input held after clr is captured on the next cycle, because count==0.
- Scan state:
  - A 20-bit divider counts 0..SCAN_DIV-1. On reaching SCAN_DIV-1 it wraps to 0 and the digit index (3 bits) increments modulo 8.
- Digit mapping:
  - index i shows entry k=i>>1;
  - odd i shows x, even i shows y;
  - so AN[0] is h0.y, AN[1] is h0.x, …, AN[7] is h3.x;
  - if k ≥ count, the digit is blank (SEG=7'h7F).
- Segment decode (active-low):
  - 0=7'b1000000
  - 1=7'b1111001
  - 2=7'b0100100
  - 3=7'b0110000
  - 4=7'b0011001
  - any other value is blank.
- Reset values:
  - count=0, entries=0, divider=0, index=0;
  - MOVED=0, LEDX=5'b00000, AN=8'hFF, SEG=7'h7F.

## Timing
- Capture latency: input present before clock edge N → history, MOVED and LEDX updated at edge N. Upstream coordinates are registered, so the comparison against h0 is combinational.
- MOVED is high for exactly one cycle per capture. A static input produces no further pulses.
- Display outputs are registered from the current index and history:
  - AN = ~(8'b1 << index);
  - AN and SEG settle one cycle after an index change or a history change.
- The index dwells exactly SCAN_DIV cycles per digit; a full frame is 8·SCAN_DIV cycles.
- The first AN drive of 8'hFE appears on the first edge after reset release.
- clr does not disturb the divider or the index; the scan continues uninterrupted.
- Reset asserted mid-scan or mid-capture immediately returns every output to its reset value. Scanning restarts from index 0.

## Test plan
- Reset: assert rst mid-scan → MOVED=0, LEDX=00000, AN=8'hFF, SEG=7'h7F immediately. After release with no valid capture, every digit is blank.
- First capture:
  - drive (0,2) → MOVED pulses one cycle, LEDX=00001;
  - hold (0,2) for 100 cycles → no further MOVED;
  - AN[0] digit shows 2 (SEG 0100100), AN[1] digit shows 0, digits 2..7 blank.
- Trail overflow: drive (0,2),(1,3),(2,4),(3,3),(4,2) on consecutive edges → 5 MOVED pulses, LEDX=10000, count=4. Digits read:
  - h0=(4,2)
  - h1=(3,3)
  - h2=(2,4)
  - h3=(1,3)
  - (0,2) dropped.
- Invalid input: drive (5,1), then (2,7) → no MOVED, history unchanged. Then (2,1) → captured.
- Scan: with SCAN_DIV=4, AN steps FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles, and wraps to FE after 32 cycles.
- clr priority: assert clr in the same cycle as new input (3,0) → no MOVED, LEDX=0, all digits blank. Deassert clr holding (3,0) → capture on the next edge, LEDX=01000.

Source files
------------

// File: rtl/puck_trail_display.sv
// Puck trail display: keeps the last four distinct puck positions and
// shows them on a 5-LED X bar and an 8-digit multiplexed 7-segment display.
module puck_trail_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [2:0] X_COORD,
    input  logic [2:0] Y_COORD,
    output logic       MOVED,
    output logic [4:0] LEDX,
    output logic [7:0] AN,
    output logic [6:0] SEG
);

    localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);
    localparam logic [2:0]  MAX_CNT  = 3'd4;
    localparam logic [6:0]  BLANK    = 7'h7F;

    logic [3:0][5:0] hist;
    logic [2:0]      count;
    logic [19:0]     div_cnt;
    logic [2:0]      idx;

    logic            in_range;
    logic            same_pos;
    logic            capture;

    logic [1:0]      k;
    logic [5:0]      ent;
    logic [2:0]      nib;
    logic            blank;
    logic [6:0]      seg_next;

    function automatic logic [6:0] seg_decode(input logic [2:0] v);
        logic [6:0] s;
        case (v)
            3'd0:    s = 7'b1000000;
            3'd1:    s = 7'b1111001;
            3'd2:    s = 7'b0100100;
            3'd3:    s = 7'b0110000;
            3'd4:    s = 7'b0011001;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    // Upstream coordinates are registered, so the h0 compare is combinational.
    always_comb begin
        in_range = (X_COORD <= 3'd4) && (Y_COORD <= 3'd4);
        same_pos = ({X_COORD, Y_COORD} == hist[0]);
        capture  = in_range && ((count == 3'd0) || !same_pos);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= '0;
            count <= '0;
            MOVED <= 1'b0;
            LEDX  <= '0;
        end else if (clr) begin
            hist  <= '0;
            count <= '0;
            MOVED <= 1'b0;
            LEDX  <= '0;
        end else begin
            MOVED <= capture;
            if (capture) begin
                hist  <= {hist[2:0], X_COORD, Y_COORD};
                count <= (count == MAX_CNT) ? MAX_CNT : count + 3'd1;
                LEDX  <= 5'b00001 << X_COORD;
            end
        end
    end

    // Scan timing runs independently of clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + 20'd1;
        end
    end

    // Digit pair k shows entry k: even digit y, odd digit x.
    always_comb begin
        k        = idx[2:1];
        ent      = hist[k];
        nib      = idx[0] ? ent[5:3] : ent[2:0];
        blank    = ({1'b0, k} >= count);
        seg_next = blank ? BLANK : seg_decode(nib);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AN  <= 8'hFF;
            SEG <= BLANK;
        end else begin
            AN  <= ~(8'h01 << idx);
            SEG <= seg_next;
        end
    end

endmodule

// File: tb/tb_puck_trail_display.sv
// Bench for puck_trail_display: MOVED/LEDX scoreboard plus directed
// display frame, scan-timing, clr and reset checks.
module tb_puck_trail_display;

    localparam int unsigned SD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [2:0] xc;
    logic [2:0] yc;
    logic       moved;
    logic [4:0] ledx;
    logic [7:0] an;
    logic [6:0] seg;

    int total = 0;
    int bad   = 0;
    logic [4:0] q[$];
    logic [4:0] exp_l;

    puck_trail_display #(.SCAN_DIV(SD)) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .X_COORD(xc),
        .Y_COORD(yc),
        .MOVED(moved),
        .LEDX(ledx),
        .AN(an),
        .SEG(seg)
    );

    always #5 clk = ~clk;

    // Monitor: every MOVED pulse must match a queued expectation.
    always @(negedge clk) begin
        if (!rst && moved) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL moved_extra: pulse with ledx=%b, none expected", ledx);
            end else begin
                exp_l = q.pop_front();
                if (ledx !== exp_l) begin
                    bad++;
                    $display("FAIL moved_ledx: got %b want %b", ledx, exp_l);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic put(input logic [2:0] x, input logic [2:0] y,
                       input logic pulse, input logic [4:0] l);
        @(posedge clk);
        #1;
        xc = x;
        yc = y;
        if (pulse) q.push_back(l);
    endtask

    task automatic check_drained(input string nm);
        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d pulses missing, want 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic check_frame(input string nm, input logic [7:0][6:0] e);
        logic [7:0] want;
        int n;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            want = ~(8'h01 << i);
            n = 0;
            while (an !== want && n < 80) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (an !== want) begin
                bad++;
                $display("FAIL %s d%0d: an=%h timeout want %h", nm, i, an, want);
            end else if (seg !== e[i]) begin
                bad++;
                $display("FAIL %s d%0d: seg=%h want %h", nm, i, seg, e[i]);
            end
        end
    endtask

    localparam logic [7:0][6:0] F_BLANK = {8{7'h7F}};
    localparam logic [7:0][6:0] F_FIRST =
        {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h24};
    localparam logic [7:0][6:0] F_OVER =
        {7'h79, 7'h30, 7'h24, 7'h19, 7'h30, 7'h30, 7'h19, 7'h24};
    localparam logic [7:0][6:0] F_INV =
        {7'h24, 7'h19, 7'h30, 7'h30, 7'h19, 7'h24, 7'h24, 7'h79};
    localparam logic [7:0][6:0] F_CLR =
        {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40};

    initial begin
        logic [7:0] w;
        int n;
        rst = 1'b1;
        clr = 1'b0;
        xc  = 3'd7;
        yc  = 3'd7;
        repeat (2) @(negedge clk);
        chk("rst_moved", {7'd0, moved}, 8'h00);
        chk("rst_ledx", {3'd0, ledx}, 8'h00);
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("an_first", an, 8'hFE);
        check_frame("blank_after_rst", F_BLANK);

        put(3'd0, 3'd2, 1'b1, 5'b00001);
        repeat (100) @(posedge clk);
        check_drained("first_pulse");
        chk("first_ledx", {3'd0, ledx}, 8'h01);
        check_frame("first_frame", F_FIRST);

        @(posedge clk);
        #1;
        clr = 1'b1;
        xc  = 3'd7;
        yc  = 3'd7;
        @(posedge clk);
        #1;
        clr = 1'b0;
        put(3'd0, 3'd2, 1'b1, 5'b00001);
        put(3'd1, 3'd3, 1'b1, 5'b00010);
        put(3'd2, 3'd4, 1'b1, 5'b00100);
        put(3'd3, 3'd3, 1'b1, 5'b01000);
        put(3'd4, 3'd2, 1'b1, 5'b10000);
        put(3'd5, 3'd1, 1'b0, 5'b00000);
        check_drained("overflow_pulses");
        chk("overflow_ledx", {3'd0, ledx}, 8'h10);
        check_frame("overflow_frame", F_OVER);

        put(3'd2, 3'd7, 1'b0, 5'b00000);
        check_drained("invalid_pulses");
        check_frame("invalid_frame", F_OVER);
        put(3'd2, 3'd1, 1'b1, 5'b00100);
        check_drained("recapture_pulse");
        check_frame("recapture_frame", F_INV);

        n = 0;
        @(negedge clk);
        while (an !== 8'h7F && n < 80) begin
            @(negedge clk);
            n++;
        end
        while (an !== 8'hFE && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("scan_sync", an, 8'hFE);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            w = ~(8'h01 << ((j / 4) % 8));
            chk($sformatf("scan_c%0d", j), an, w);
        end

        @(posedge clk);
        #1;
        clr = 1'b1;
        xc  = 3'd3;
        yc  = 3'd0;
        @(posedge clk);
        @(negedge clk);
        chk("clr_moved", {7'd0, moved}, 8'h00);
        chk("clr_ledx", {3'd0, ledx}, 8'h00);
        check_frame("clr_frame", F_BLANK);
        @(posedge clk);
        #1;
        clr = 1'b0;
        q.push_back(5'b01000);
        check_drained("after_clr_pulse");
        chk("after_clr_ledx", {3'd0, ledx}, 8'h08);
        check_frame("after_clr_frame", F_CLR);

        repeat (5) @(posedge clk);
        #3;
        xc  = 3'd1;
        yc  = 3'd1;
        rst = 1'b1;
        #1;
        chk("midrst_moved", {7'd0, moved}, 8'h00);
        chk("midrst_ledx", {3'd0, ledx}, 8'h00);
        chk("midrst_an", an, 8'hFF);
        chk("midrst_seg", {1'b0, seg}, 8'h7F);
        xc = 3'd7;
        yc = 3'd7;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_an_first", an, 8'hFE);
        check_frame("midrst_frame", F_BLANK);
        check_drained("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
